// File: rtl/reset_sequencer.sv
// reset_sequencer: holds downstream resets until PLL lock is stable, then releases them
// one at a time with fixed spacing; re-runs the sequence on soft request or lock loss.
module reset_sequencer #(
    parameter int N_OUT       = 3,
    parameter int DELAY       = 24,
    parameter int LOCK_STABLE = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             soft_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic             soft_ack
);
    localparam int MAX_DL = DELAY > LOCK_STABLE ? DELAY : LOCK_STABLE;
    localparam int MAX_V  = MAX_DL > HOLD_CYCLES ? MAX_DL : HOLD_CYCLES;
    localparam int CW     = MAX_V > 1 ? $clog2(MAX_V) : 1;
    localparam int IW     = N_OUT > 1 ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN, SOFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] rst_q, rst_d;
    logic             ready_q, ready_d;
    logic             ack_q, ack_d;
    logic [1:0]       sync_q;
    logic             lock_s;

    assign lock_s   = sync_q[1];
    assign rst_out  = rst_q;
    assign ready    = ready_q;
    assign soft_ack = ack_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            sync_q  <= {sync_q[0], pll_locked};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        // lock loss outranks everything, including a soft request in RUN
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(DELAY - 1)) begin
                        rst_d[idx_q] = 1'b0;
                        cnt_d        = '0;
                        idx_d        = idx_q + 1'b1;
                        if (idx_q == IW'(N_OUT - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_req) begin
                        state_d = SOFT;
                        rst_d   = '1;
                        ready_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                SOFT: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_d = RELEASE;
                        ack_d   = 1'b1;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus pushes expected output changes (edge, value) into
// a queue; an independent monitor pops one entry on every observed output change.
module tb_reset_sequencer;
    typedef struct {
        int         e;
        logic [2:0] r;
        logic       rd;
        logic       ak;
        logic       ph;
    } exp_t;

    logic       clk = 1'b1;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_req;
    logic [2:0] rst_out;
    logic       ready;
    logic       soft_ack;

    int   edge_n = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    reset_sequencer #(.N_OUT(3), .DELAY(24), .LOCK_STABLE(16), .HOLD_CYCLES(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .soft_req  (soft_req),
        .rst_out   (rst_out),
        .ready     (ready),
        .soft_ack  (soft_ack)
    );

    always #5 clk = ~clk;

    // edge 1 is the first rising edge after reset_n deasserts
    always @(posedge clk or negedge reset_n)
        if (!reset_n) edge_n <= 0;
        else edge_n <= edge_n + 1;

    task automatic ex(input int e, input logic [2:0] r, input logic rd, input logic ak, input logic ph);
        exp_t x;
        x.e = e; x.r = r; x.rd = rd; x.ak = ak; x.ph = ph;
        q.push_back(x);
    endtask

    task automatic drive_before(input int n);
        int g;
        g = 0;
        while (edge_n < n - 1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (edge_n != n - 1) begin
            miscompares++;
            $display("FAIL drive_timing: at edge %0d, wanted edge %0d", edge_n, n - 1);
        end
    endtask

    task automatic power_up_expect();
        ex(42, 3'b110, 1'b0, 1'b0, 1'b0);
        ex(66, 3'b100, 1'b0, 1'b0, 1'b0);
        ex(90, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    // ph records whether a change was seen right after reset_n fell (clk high) or at a negedge
    initial begin
        logic [4:0] prev, cur;
        logic       ph;
        exp_t       x;
        prev = 'x;
        forever begin
            @(negedge clk or negedge reset_n);
            ph = clk;
            #1;
            cur = {rst_out, ready, soft_ack};
            if (cur !== prev) begin
                prev = cur;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change: edge=%0d got rst=%b rdy=%b ack=%b, none expected",
                             edge_n, rst_out, ready, soft_ack);
                end else begin
                    x = q.pop_front();
                    if (x.e != edge_n || x.r !== rst_out || x.rd !== ready || x.ak !== soft_ack || x.ph !== ph) begin
                        miscompares++;
                        $display("FAIL change@%0d: got edge=%0d rst=%b rdy=%b ack=%b ph=%b, want edge=%0d rst=%b rdy=%b ack=%b ph=%b",
                                 x.e, edge_n, rst_out, ready, soft_ack, ph, x.e, x.r, x.rd, x.ak, x.ph);
                    end
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        soft_req   = 1'b0;
        ex(0, 3'b111, 1'b0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        power_up_expect();
        // soft reset from RUN
        drive_before(100);
        soft_req = 1'b1;
        ex(100, 3'b111, 1'b0, 1'b0, 1'b0);
        ex(108, 3'b111, 1'b0, 1'b1, 1'b0);
        ex(109, 3'b111, 1'b0, 1'b0, 1'b0);
        ex(132, 3'b110, 1'b0, 1'b0, 1'b0);
        ex(156, 3'b100, 1'b0, 1'b0, 1'b0);
        ex(180, 3'b000, 1'b1, 1'b0, 1'b0);
        drive_before(101);
        soft_req = 1'b0;
        // lock loss in RUN racing a soft request, then a lock glitch while re-counting
        drive_before(200);
        pll_locked = 1'b0;
        ex(202, 3'b111, 1'b0, 1'b0, 1'b0);
        drive_before(202);
        soft_req = 1'b1;
        drive_before(206);
        soft_req = 1'b0;
        drive_before(210);
        pll_locked = 1'b1;
        drive_before(221);
        pll_locked = 1'b0;
        drive_before(222);
        pll_locked = 1'b1;
        ex(263, 3'b110, 1'b0, 1'b0, 1'b0);
        ex(287, 3'b100, 1'b0, 1'b0, 1'b0);
        ex(311, 3'b000, 1'b1, 1'b0, 1'b0);
        // lock loss after rst_out[0] released
        drive_before(330);
        soft_req = 1'b1;
        ex(330, 3'b111, 1'b0, 1'b0, 1'b0);
        ex(338, 3'b111, 1'b0, 1'b1, 1'b0);
        ex(339, 3'b111, 1'b0, 1'b0, 1'b0);
        ex(362, 3'b110, 1'b0, 1'b0, 1'b0);
        drive_before(331);
        soft_req = 1'b0;
        drive_before(370);
        pll_locked = 1'b0;
        ex(372, 3'b111, 1'b0, 1'b0, 1'b0);
        drive_before(380);
        pll_locked = 1'b1;
        ex(421, 3'b110, 1'b0, 1'b0, 1'b0);
        ex(445, 3'b100, 1'b0, 1'b0, 1'b0);
        ex(469, 3'b000, 1'b1, 1'b0, 1'b0);
        // async reset while in SOFT, then a fresh power-up
        drive_before(500);
        soft_req = 1'b1;
        ex(500, 3'b111, 1'b0, 1'b0, 1'b0);
        drive_before(501);
        soft_req = 1'b0;
        drive_before(505);
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        power_up_expect();
        // async reset in RUN must act between clock edges
        drive_before(120);
        ex(0, 3'b111, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ex(42, 3'b110, 1'b0, 1'b0, 1'b0);
        drive_before(50);
        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expect: %0d expected changes never seen, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
